// File: rtl/intr_trap_ctrl_if.sv
// Interrupt/trap handshake bundle between the CSR/pipeline side (master)
// and the interrupt trap sequencer (slave).
interface intr_trap_ctrl_if #(
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0] irq_src;
    logic [N_SRC-1:0] irq_mask;
    logic             mie_global;
    logic             irq_ack;
    logic             mret;
    logic             irq_req;
    logic [31:0]      irq_cause;
    logic             trap_active;
    logic [N_SRC-1:0] irq_pending;

    modport master (
        output irq_src, irq_mask, mie_global, irq_ack, mret,
        input  irq_req, irq_cause, trap_active, irq_pending
    );

    modport slave (
        input  irq_src, irq_mask, mie_global, irq_ack, mret,
        output irq_req, irq_cause, trap_active, irq_pending
    );
endinterface

// File: rtl/intr_trap_ctrl.sv
// Interrupt controller / trap sequencer for the 3-stage RISC-V pipeline.
// Edge-detects N_SRC interrupt lines into pending bits, arbitrates among the
// enabled ones and hands a single trap at a time to the pipeline through a
// req/ack handshake. No nesting: a new trap waits until mret retires.
// Build option: define INTR_RR_EN for round-robin arbitration; otherwise the
// lowest eligible index wins and no pointer logic is built.
module intr_trap_ctrl #(
    parameter int N_SRC      = 4,
    parameter int CAUSE_BASE = 16
) (
    input  logic             clk,
    input  logic             reset,
    intr_trap_ctrl_if.slave  bus
);
    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] rise, eligible, clear;
    logic             req_q, req_d;
    logic             trap_q, trap_d;
    logic [31:0]      cause_q, cause_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] pick;
    logic             found;

    assign rise     = bus.irq_src & ~src_q;
    assign eligible = pending_q & bus.irq_mask;
    assign found    = |eligible;

`ifdef INTR_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Round-robin pick: eligible source nearest after the last granted index
    always_comb begin
        int start;
        int dist;
        int best;
        pick  = '0;
        best  = N_SRC;
        dist  = 0;
        start = (int'(ptr_q) + 1) % N_SRC;
        for (int i = 0; i < N_SRC; i++) begin
            dist = (i + N_SRC - start) % N_SRC;
            if (eligible[i] && (dist < best)) begin
                best = dist;
                pick = IDX_W'(i);
            end
        end
    end

    // Last-granted pointer, moved only when a trap is acknowledged
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= IDX_W'(N_SRC - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority pick: lowest eligible index wins
    always_comb begin
        pick = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                pick = IDX_W'(i);
            end
        end
    end
`endif

    // Trap sequencing: arbitrate in IDLE, hold the request until ack, then wait for mret
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        trap_d  = trap_q;
        cause_d = cause_q;
        grant_d = grant_q;
        clear   = '0;
`ifdef INTR_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.mie_global && found) begin
                    grant_d = pick;
                    cause_d = {1'b1, 31'(CAUSE_BASE + int'(pick))};
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.irq_ack) begin
                    req_d   = 1'b0;
                    trap_d  = 1'b1;
                    for (int i = 0; i < N_SRC; i++) begin
                        clear[i] = (grant_q == IDX_W'(i));
                    end
`ifdef INTR_RR_EN
                    ptr_d   = grant_q;
`endif
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (bus.mret) begin
                    trap_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A new event on the index being acknowledged survives the clear
        pending_d = (pending_q & ~clear) | rise;
    end

    // State, handshake and pending registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            src_q     <= '0;
            pending_q <= '0;
            req_q     <= 1'b0;
            trap_q    <= 1'b0;
            cause_q   <= '0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= bus.irq_src;
            pending_q <= pending_d;
            req_q     <= req_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
            grant_q   <= grant_d;
        end
    end

    assign bus.irq_req     = req_q;
    assign bus.irq_cause   = cause_q;
    assign bus.trap_active = trap_q;
    assign bus.irq_pending = pending_q;
endmodule

// File: tb/tb_intr_trap_ctrl.sv
// Testbench for intr_trap_ctrl: directed vector table, a round-robin/fixed
// grant sequence and randomized traffic against a behavioural model.
module tb_intr_trap_ctrl;
    localparam int N = 4;
    localparam logic [31:0] C10 = 32'h8000_0010;
    localparam logic [31:0] C11 = 32'h8000_0011;
    localparam logic [31:0] C12 = 32'h8000_0012;
    localparam logic [31:0] C13 = 32'h8000_0013;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    intr_trap_ctrl_if #(.N_SRC(N)) bus ();

    intr_trap_ctrl #(
        .N_SRC      (N),
        .CAUSE_BASE (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic [3:0]  src;
        logic [3:0]  mask;
        logic        mie;
        logic        ack;
        logic        mret;
        logic        eReq;
        logic [31:0] eCause;
        logic        eTrap;
        logic [3:0]  ePend;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state
    bit          mReq;
    bit          mActive;
    int          mGrant;
    int          mLast;
    logic [31:0] mCause;
    bit          mPend[N];
    bit          mPrev[N];

    function automatic void addV(input logic r, input logic [3:0] s, input logic [3:0] m,
                                 input logic mi, input logic a, input logic mr,
                                 input logic eq, input logic [31:0] ec,
                                 input logic et, input logic [3:0] ep);
        vec_t v;
        v.rst = r; v.src = s; v.mask = m; v.mie = mi; v.ack = a; v.mret = mr;
        v.eReq = eq; v.eCause = ec; v.eTrap = et; v.ePend = ep;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic r, input logic [3:0] s, input logic [3:0] m,
                                 input logic mi, input logic a, input logic mr);
        reset          = r;
        bus.irq_src    = s;
        bus.irq_mask   = m;
        bus.mie_global = mi;
        bus.irq_ack    = a;
        bus.mret       = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic eReq, input logic [31:0] eCause,
                               input logic eTrap, input logic [3:0] ePend);
        total++;
        if (bus.irq_req !== eReq || bus.irq_cause !== eCause ||
            bus.trap_active !== eTrap || bus.irq_pending !== ePend) begin
            bad++;
            $display("[TB] FAIL %s: req=%0b/%0b cause=%h/%h trap=%0b/%0b pend=%b/%b (actual/required)",
                     name, bus.irq_req, eReq, bus.irq_cause, eCause,
                     bus.trap_active, eTrap, bus.irq_pending, ePend);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // One clock of the reference behaviour, evaluated with the inputs about to be sampled
    function automatic void modelStep(input logic r, input logic [3:0] s, input logic [3:0] m,
                                      input logic mi, input logic a, input logic mr);
        bit newPend[N];
        int winner;
        if (r) begin
            mReq = 0; mActive = 0; mGrant = 0; mLast = N - 1; mCause = '0;
            for (int i = 0; i < N; i++) begin
                mPend[i] = 0;
                mPrev[i] = 0;
            end
            return;
        end
        newPend = mPend;
        winner  = -1;
        if (!mReq && !mActive) begin
            if (mi) begin
`ifdef INTR_RR_EN
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (mLast + k) % N;
                    if (winner < 0 && mPend[idx] && m[idx]) winner = idx;
                end
`else
                for (int i = 0; i < N; i++) begin
                    if (winner < 0 && mPend[i] && m[i]) winner = i;
                end
`endif
            end
            if (winner >= 0) begin
                mReq   = 1;
                mGrant = winner;
                mCause = 32'h8000_0000 + 32'(16 + winner);
            end
        end else if (mReq) begin
            if (a) begin
                mReq            = 0;
                mActive         = 1;
                newPend[mGrant] = 0;
                mLast           = mGrant;
            end
        end else if (mr) begin
            mActive = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (s[i] && !mPrev[i]) newPend[i] = 1;
            mPrev[i] = s[i];
        end
        mPend = newPend;
    endfunction

    function automatic logic [3:0] modelPend();
        logic [3:0] p;
        for (int i = 0; i < N; i++) p[i] = mPend[i];
        return p;
    endfunction

    initial begin
        int expG[4];
        int waited;
        logic       r, mi, a, mr;
        logic [3:0] s, m;

        total = 0;
        bad   = 0;
        applyStimulus(1, 4'h0, 4'hF, 1, 0, 0);

        // Directed table (fixed-priority expectations)
        addV(1,4'h0,4'hF,1,0,0, 0,32'h0,0,4'h0);
        addV(0,4'h4,4'hF,1,0,0, 0,32'h0,0,4'h4);
        addV(0,4'h0,4'hF,1,0,0, 1,C12,0,4'h4);
        addV(0,4'h0,4'hF,1,0,0, 1,C12,0,4'h4);
        addV(0,4'h0,4'hF,1,1,0, 0,C12,1,4'h0);
        addV(0,4'h0,4'hF,1,0,0, 0,C12,1,4'h0);
        addV(0,4'h0,4'hF,1,0,1, 0,C12,0,4'h0);
        addV(0,4'h0,4'hF,1,0,0, 0,C12,0,4'h0);
        addV(0,4'hA,4'hF,1,0,0, 0,C12,0,4'hA);
        addV(0,4'h0,4'hF,1,0,0, 1,C11,0,4'hA);
        addV(0,4'h0,4'hF,1,1,0, 0,C11,1,4'h8);
        addV(0,4'h0,4'hF,1,0,1, 0,C11,0,4'h8);
        addV(0,4'h0,4'hF,1,0,0, 1,C13,0,4'h8);
        addV(0,4'h0,4'hF,1,1,0, 0,C13,1,4'h0);
        addV(0,4'h0,4'hF,1,0,1, 0,C13,0,4'h0);
        addV(0,4'h1,4'hF,0,0,0, 0,C13,0,4'h1);
        addV(0,4'h0,4'hF,0,0,0, 0,C13,0,4'h1);
        addV(0,4'h0,4'hF,1,0,0, 1,C10,0,4'h1);
        addV(0,4'h0,4'hF,1,1,0, 0,C10,1,4'h0);
        addV(0,4'h8,4'hF,1,0,0, 0,C10,1,4'h8);
        addV(0,4'h0,4'hF,1,0,0, 0,C10,1,4'h8);
        addV(0,4'h0,4'hF,1,0,1, 0,C10,0,4'h8);
        addV(0,4'h0,4'hF,1,0,0, 1,C13,0,4'h8);
        addV(1,4'h0,4'hF,1,0,0, 0,32'h0,0,4'h0);
        addV(0,4'h0,4'hF,1,1,0, 0,32'h0,0,4'h0);
        addV(0,4'h0,4'hF,1,0,0, 0,32'h0,0,4'h0);
        addV(0,4'h8,4'h7,1,0,0, 0,32'h0,0,4'h8);
        addV(0,4'h0,4'h7,1,0,0, 0,32'h0,0,4'h8);
        addV(0,4'h0,4'h7,1,0,0, 0,32'h0,0,4'h8);
        addV(0,4'h0,4'hF,1,0,0, 1,C13,0,4'h8);
        addV(0,4'h0,4'hF,1,1,0, 0,C13,1,4'h0);
        addV(0,4'h0,4'hF,1,0,1, 0,C13,0,4'h0);
        addV(1,4'h1,4'hF,1,0,0, 0,32'h0,0,4'h0);
        addV(0,4'h1,4'hF,1,0,0, 0,32'h0,0,4'h1);
        addV(0,4'h1,4'hF,1,0,0, 1,C10,0,4'h1);
        addV(0,4'h1,4'hF,1,1,0, 0,C10,1,4'h0);
        addV(0,4'h1,4'hF,1,0,0, 0,C10,1,4'h0);
        addV(0,4'h1,4'hF,1,0,1, 0,C10,0,4'h0);
        addV(0,4'h1,4'hF,1,0,0, 0,C10,0,4'h0);
        addV(0,4'h0,4'hF,1,0,0, 0,C10,0,4'h0);
        addV(0,4'h2,4'hF,1,0,0, 0,C10,0,4'h2);
        addV(0,4'h0,4'hF,1,0,0, 1,C11,0,4'h2);
        addV(0,4'h2,4'hF,1,1,0, 0,C11,1,4'h2);
        addV(0,4'h0,4'hF,1,0,1, 0,C11,0,4'h2);
        addV(0,4'h0,4'hF,1,0,0, 1,C11,0,4'h2);
        addV(0,4'h0,4'hF,1,1,0, 0,C11,1,4'h0);
        addV(0,4'h0,4'hF,1,0,1, 0,C11,0,4'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].src, vecs[i].mask,
                          vecs[i].mie, vecs[i].ack, vecs[i].mret);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].eReq, vecs[i].eCause,
                        vecs[i].eTrap, vecs[i].ePend);
        end

        // Repeated src[0]/src[1] events with one trap in service each round
`ifdef INTR_RR_EN
        expG = '{0, 1, 0, 1};
`else
        expG = '{0, 0, 0, 0};
`endif
        applyStimulus(1, 4'h0, 4'hF, 1, 0, 0);
        tick();
        applyStimulus(0, 4'h3, 4'hF, 1, 0, 0);
        tick();
        applyStimulus(0, 4'h0, 4'hF, 1, 0, 0);
        tick();
        for (int rnd = 0; rnd < 4; rnd++) begin
            waited = 0;
            while (!bus.irq_req && waited < 10) begin
                tick();
                waited++;
            end
            checkValue($sformatf("grant%0d_req", rnd), {31'd0, bus.irq_req}, 32'd1);
            checkValue($sformatf("grant%0d_cause", rnd), bus.irq_cause, C10 + 32'(expG[rnd]));
            applyStimulus(0, 4'h0, 4'hF, 1, 1, 0);
            tick();
            applyStimulus(0, 4'h3, 4'hF, 1, 0, 0);
            tick();
            applyStimulus(0, 4'h0, 4'hF, 1, 0, 0);
            tick();
            applyStimulus(0, 4'h0, 4'hF, 1, 0, 1);
            tick();
            applyStimulus(0, 4'h0, 4'hF, 1, 0, 0);
        end

        // Randomized traffic against the reference model
        m = 4'hF;
        for (int c = 0; c < 3000; c++) begin
            r  = (c == 0) || ($urandom_range(0, 199) == 0);
            s  = 4'($urandom & $urandom);
            if ($urandom_range(0, 39) == 0) m = 4'($urandom);
            mi = ($urandom_range(0, 7) != 0);
            a  = mReq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            mr = mActive ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            applyStimulus(r, s, m, mi, a, mr);
            modelStep(r, s, m, mi, a, mr);
            tick();
            checkOutput($sformatf("rand%0d", c), mReq, mCause, mActive, modelPend());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
